// File: rtl/filter_pkg.sv
// Shared definitions for the filter processor execute stage: opcodes, lane
// geometry defaults, FSM states and lane saturation/clamp helpers.
package filter_pkg;

    localparam int LANES_DEF  = 4;
    localparam int LANE_W_DEF = 8;
    localparam int ACC_W_DEF  = 20;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD8 = 3'b001;
    localparam logic [2:0] OP_SUB8 = 3'b010;
    localparam logic [2:0] OP_AVG8 = 3'b011;
    localparam logic [2:0] OP_MAC  = 3'b100;
    localparam logic [2:0] OP_MAX8 = 3'b101;
    localparam logic [2:0] OP_MIN8 = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    function automatic logic [LANE_W_DEF-1:0] sat_add(
        input logic [LANE_W_DEF-1:0] a,
        input logic [LANE_W_DEF-1:0] b
    );
        logic [LANE_W_DEF:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[LANE_W_DEF] ? {LANE_W_DEF{1'b1}} : sum[LANE_W_DEF-1:0];
    endfunction

    function automatic logic [LANE_W_DEF-1:0] sat_sub(
        input logic [LANE_W_DEF-1:0] a,
        input logic [LANE_W_DEF-1:0] b
    );
        return (a < b) ? {LANE_W_DEF{1'b0}} : (a - b);
    endfunction

    // Clamp a signed value into the unsigned pixel range [0, 255].
    function automatic logic [7:0] clamp_u8(input logic signed [31:0] v);
        logic [7:0] r;
        if (v < 32'sd0) begin
            r = 8'h00;
        end else if (v > 32'sd255) begin
            r = 8'hFF;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/filter_exec_stage_lane_alu.sv
// One 8-bit lane of the single-cycle pixel ALU (ADD/SUB/AVG/MAX/MIN).
module filter_lane_alu
    import filter_pkg::*;
#(
    parameter int LANE_W = LANE_W_DEF
) (
    input  logic [2:0]        op,
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] y
);

    logic [LANE_W:0] avg_sum_s;

    assign avg_sum_s = {1'b0, a} + {1'b0, b} + {{LANE_W{1'b0}}, 1'b1};

    // Per-lane result select; NOP, MAC and reserved yield zero.
    always_comb begin
        y = {LANE_W{1'b0}};
        case (op)
            OP_ADD8: y = sat_add(a, b);
            OP_SUB8: y = sat_sub(a, b);
            OP_AVG8: y = avg_sum_s[LANE_W:1];
            OP_MAX8: y = (a > b) ? a : b;
            OP_MIN8: y = (a < b) ? a : b;
            default: y = {LANE_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/filter_exec_stage.sv
// Filter processor execute stage: single-cycle lane-wise pixel ops plus a
// multi-cycle 4-tap MAC that stalls the upstream register while busy.
module filter_exec_stage
    import filter_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int LANE_W = LANE_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              op,
    input  logic [3:0]              rd,
    input  logic [3:0]              shift,
    input  logic [LANES*LANE_W-1:0] src_a,
    input  logic [LANES*LANE_W-1:0] src_b,
    output logic                    out_valid,
    output logic                    out_we,
    output logic [3:0]              out_rd,
    output logic [LANES*LANE_W-1:0] out_data
);

    localparam int DATA_W = LANES * LANE_W;
    localparam int CNT_W  = $clog2(LANES + 1);
    localparam logic [CNT_W-1:0] LANE_LAST = CNT_W'(LANES);

    state_t                     state_r, state_nxt_s;
    logic [CNT_W-1:0]           lane_r;
    logic signed [ACC_W-1:0]    acc_r;
    logic [DATA_W-1:0]          a_r, b_r;
    logic [3:0]                 shift_r, rd_r;

    logic                       accept_s, is_mac_s, writes_s, fin_s, acc_step_s;
    logic [DATA_W-1:0]          alu_y_s;
    logic signed [2*LANE_W:0]   pix_s, coef_s, prod_s;
    logic signed [ACC_W-1:0]    prod_ext_s, shifted_s;
    logic [7:0]                 mac_res_s;

    logic                       res_valid_s, res_we_s;
    logic [3:0]                 res_rd_s;
    logic [DATA_W-1:0]          res_data_s;

    assign in_ready   = (state_r == ST_IDLE) && !rst;
    assign accept_s   = in_valid && in_ready;
    assign is_mac_s   = (op == OP_MAC);
    assign writes_s   = (op != OP_NOP) && (op != OP_RSVD);
    assign fin_s      = (state_r == ST_ACC) && (lane_r == LANE_LAST);
    assign acc_step_s = (state_r == ST_ACC) && (lane_r != LANE_LAST);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        filter_lane_alu #(.LANE_W(LANE_W)) u_alu (
            .op (op),
            .a  (src_a[i*LANE_W +: LANE_W]),
            .b  (src_b[i*LANE_W +: LANE_W]),
            .y  (alu_y_s[i*LANE_W +: LANE_W])
        );
    end

    // Operand registers shift down one lane per step, so the MAC always uses lane 0.
    assign pix_s      = {{(LANE_W+1){1'b0}}, a_r[LANE_W-1:0]};
    assign coef_s     = {{(LANE_W+1){b_r[LANE_W-1]}}, b_r[LANE_W-1:0]};
    assign prod_s     = pix_s * coef_s;
    assign prod_ext_s = {{(ACC_W-2*LANE_W-1){prod_s[2*LANE_W]}}, prod_s};
    assign shifted_s  = acc_r >>> shift_r;
    assign mac_res_s  = clamp_u8(32'(shifted_s));

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && is_mac_s) begin
                    state_nxt_s = ST_ACC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (fin_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ACC;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Result selection: single-cycle result at accept, MAC result on its final edge.
    always_comb begin
        res_valid_s = 1'b0;
        res_we_s    = 1'b0;
        res_rd_s    = out_rd;
        res_data_s  = out_data;
        if (accept_s && !is_mac_s) begin
            res_valid_s = 1'b1;
            res_we_s    = writes_s;
            res_rd_s    = rd;
            res_data_s  = writes_s ? alu_y_s : {DATA_W{1'b0}};
        end else if (fin_s) begin
            res_valid_s = 1'b1;
            res_we_s    = 1'b1;
            res_rd_s    = rd_r;
            res_data_s  = {{(DATA_W-8){1'b0}}, mac_res_s};
        end else begin
            res_valid_s = 1'b0;
            res_we_s    = 1'b0;
        end
    end

    // MAC operand capture and accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r   <= {ACC_W{1'b0}};
            lane_r  <= {CNT_W{1'b0}};
            a_r     <= {DATA_W{1'b0}};
            b_r     <= {DATA_W{1'b0}};
            shift_r <= 4'd0;
            rd_r    <= 4'd0;
        end else if (accept_s && is_mac_s) begin
            acc_r   <= {ACC_W{1'b0}};
            lane_r  <= {CNT_W{1'b0}};
            a_r     <= src_a;
            b_r     <= src_b;
            shift_r <= shift;
            rd_r    <= rd;
        end else if (acc_step_s) begin
            acc_r   <= acc_r + prod_ext_s;
            lane_r  <= lane_r + CNT_W'(1);
            a_r     <= a_r >> LANE_W;
            b_r     <= b_r >> LANE_W;
        end
    end

    // Registered writeback outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_we    <= 1'b0;
            out_rd    <= 4'd0;
            out_data  <= {DATA_W{1'b0}};
        end else begin
            out_valid <= res_valid_s;
            out_we    <= res_we_s;
            out_rd    <= res_rd_s;
            out_data  <= res_data_s;
        end
    end

endmodule

// File: tb/tb_filter_exec_stage.sv
// Self-checking bench for filter_exec_stage: vector table, scoreboard and
// hand-written MAC stall/reset sequences.
module tb_filter_exec_stage;
    import filter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [3:0]  rd = 4'd0;
    logic [3:0]  shift = 4'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        out_valid, out_we;
    logic [3:0]  out_rd;
    logic [31:0] out_data;

    always #5 clk = ~clk;

    filter_exec_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rd(rd), .shift(shift), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_we(out_we), .out_rd(out_rd), .out_data(out_data)
    );

    typedef struct {
        logic [3:0]  rd;
        logic        we;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  rd;
        logic [3:0]  shift;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        logic        we;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[11];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: integer arithmetic per lane, signed MAC over the 4 taps.
    function automatic exp_t model(input vec_t v);
        exp_t e;
        int   acc, r, x, y;
        e.rd   = v.rd;
        e.we   = (v.op != OP_NOP) && (v.op != OP_RSVD);
        e.data = 32'd0;
        acc = 0;
        if (v.op == OP_MAC) begin
            for (int i = 0; i < 4; i++) begin
                x = int'(v.a[8*i +: 8]);
                y = int'(v.b[8*i +: 8]);
                if (y > 127) y = y - 256;
                acc = acc + x * y;
            end
            r = acc >>> v.shift;
            if (r < 0) r = 0;
            if (r > 255) r = 255;
            e.data = 32'(r);
        end else if (e.we) begin
            for (int i = 0; i < 4; i++) begin
                x = int'(v.a[8*i +: 8]);
                y = int'(v.b[8*i +: 8]);
                case (v.op)
                    OP_ADD8: r = (x + y > 255) ? 255 : x + y;
                    OP_SUB8: r = (x > y) ? x - y : 0;
                    OP_AVG8: r = (x + y + 1) / 2;
                    OP_MAX8: r = (x > y) ? x : y;
                    OP_MIN8: r = (x < y) ? x : y;
                    default: r = 0;
                endcase
                e.data[8*i +: 8] = 8'(r);
            end
        end
        return e;
    endfunction

    // Scoreboard: every out_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got out_valid=1 data=%h, expected no result", out_data);
            end else begin
                e = sb.pop_front();
                check("out_data", out_data, e.data);
                check("out_we", {31'd0, out_we}, {31'd0, e.we});
                if (e.we) check("out_rd", {28'd0, out_rd}, {28'd0, e.rd});
            end
        end
    end

    task automatic issue(input vec_t v, input exp_t e);
        int waitc;
        waitc = 0;
        @(negedge clk);
        op = v.op; rd = v.rd; shift = v.shift; src_a = v.a; src_b = v.b;
        in_valid = 1'b1;
        while (!in_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got in_ready=0 for 20 cycles, expected 1");
            in_valid = 1'b0;
        end else begin
            sb.push_back(e);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (v.op == OP_MAC) check("mac_busy_rdy", {31'd0, in_ready}, 32'd0);
            else                check("lat1_valid", {31'd0, out_valid}, 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200us");
        $fatal(1);
    end

    initial begin
        vec_t v;
        exp_t e;

        tbl[0]  = '{OP_ADD8, 4'd1,  4'd0, 32'h10F08001, 32'h012080FF, 32'h11FFFFFF, 1'b1};
        tbl[1]  = '{OP_SUB8, 4'd2,  4'd0, 32'h051000FF, 32'h06080101, 32'h000800FE, 1'b1};
        tbl[2]  = '{OP_AVG8, 4'd3,  4'd0, 32'h00FF0310, 32'h01FF0420, 32'h01FF0418, 1'b1};
        tbl[3]  = '{OP_NOP,  4'd4,  4'd0, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0};
        tbl[4]  = '{OP_RSVD, 4'd5,  4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0};
        tbl[5]  = '{OP_MAX8, 4'd6,  4'd0, 32'h00FF7F80, 32'h01FE8080, 32'h01FF8080, 1'b1};
        tbl[6]  = '{OP_MIN8, 4'd7,  4'd0, 32'h00FF7F80, 32'h01FE8080, 32'h00FE7F80, 1'b1};
        tbl[7]  = '{OP_MAC,  4'd8,  4'd0, 32'h10101010, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        tbl[8]  = '{OP_MAC,  4'd9,  4'd0, 32'hFFFFFFFF, 32'h7F7F7F7F, 32'h000000FF, 1'b1};
        tbl[9]  = '{OP_MAC,  4'd10, 4'd2, 32'h10203040, 32'h010201FF, 32'h00000010, 1'b1};
        tbl[10] = '{OP_ADD8, 4'd11, 4'd0, 32'h01010101, 32'h02020202, 32'h03030303, 1'b1};

        #12;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_we",    {31'd0, out_we},    32'd0);
        check("rst_data",  out_data,           32'd0);
        check("rst_rd",    {28'd0, out_rd},    32'd0);
        check("rst_ready", {31'd0, in_ready},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 11; i++) begin
            e = '{tbl[i].rd, tbl[i].we, tbl[i].data};
            issue(tbl[i], e);
        end

        // MAC latency and stall with an instruction held upstream.
        for (int w = 0; w < 20 && !in_ready; w++) @(negedge clk);
        @(negedge clk);
        op = OP_MAC; rd = 4'd12; shift = 4'd2; src_a = 32'h10203040; src_b = 32'h010201FF;
        in_valid = 1'b1;
        check("mac_accept_rdy", {31'd0, in_ready}, 32'd1);
        sb.push_back('{4'd12, 1'b1, 32'h00000010});
        @(negedge clk);
        op = OP_SUB8; rd = 4'd13; shift = 4'd0; src_a = 32'h20202020; src_b = 32'h10101010;
        for (int k = 1; k <= 5; k++) begin
            check("mac_stall_rdy",   {31'd0, in_ready},  32'd0);
            check("mac_stall_valid", {31'd0, out_valid}, 32'd0);
            @(negedge clk);
        end
        check("mac_lat_valid", {31'd0, out_valid}, 32'd1);
        check("mac_rdy_back",  {31'd0, in_ready},  32'd1);
        sb.push_back('{4'd13, 1'b1, 32'h10101010});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("held_lat_valid", {31'd0, out_valid}, 32'd1);

        // Reset on the second ACC cycle of a MAC aborts it.
        @(negedge clk);
        op = OP_MAC; rd = 4'd14; shift = 4'd0; src_a = 32'h01010101; src_b = 32'h01010101;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_we",    {31'd0, out_we},    32'd0);
        check("arst_data",  out_data,           32'd0);
        check("arst_rd",    {28'd0, out_rd},    32'd0);
        check("arst_ready", {31'd0, in_ready},  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_release_rdy", {31'd0, in_ready}, 32'd1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("abort_no_valid", {31'd0, out_valid}, 32'd0);
        end

        // Random vectors against the reference model.
        for (int n = 0; n < 24; n++) begin
            v.op    = 3'($urandom_range(0, 7));
            v.rd    = 4'($urandom_range(0, 15));
            v.shift = 4'($urandom_range(0, 15));
            v.a     = $urandom;
            v.b     = $urandom;
            v.data  = 32'd0;
            v.we    = 1'b0;
            issue(v, model(v));
        end

        for (int w = 0; w < 20 && sb.size() != 0; w++) @(negedge clk);
        check("sb_drain", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
